// File: rtl/scan_decoder_pkg.sv
// Shared definitions for the scan decoder: mode encodings and output-width helper.
package scan_decoder_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  function automatic int out_w(input int sel_w);
    return 1 << sel_w;
  endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Control and strobe bundle between a scan decoder and whatever drives it.
interface scan_decoder_if
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W = 3
);
  localparam int OUT_W = out_w(SEL_W);

  logic             en;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] last;
  logic             load;
  logic [OUT_W-1:0] out;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  modport master (output en, mode, sel, last, load, input out, idx, wrap);
  modport slave  (input en, mode, sel, last, load, output out, idx, wrap);
endinterface

// File: rtl/scan_decoder_tick.sv
// Scan prescaler: tick is high while the count sits at PRESCALE-1.
module tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic hold,
  output logic tick
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pc;

  assign tick = (pc == PW'(PRESCALE - 1));

  // hold outranks clear so a disabled decoder keeps its place in the step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pc <= '0;
    else if (hold)           pc <= pc;
    else if (clear || tick)  pc <= '0;
    else                     pc <= pc + 1'b1;
  end
endmodule

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with direct and prescaled auto-scan modes.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int PRESCALE   = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  scan_decoder_if.slave bus
);
  localparam int OUT_W = out_w(SEL_W);
  localparam logic [OUT_W-1:0] OUT_IDLE = {OUT_W{ACTIVE_LOW}};

  logic             tick, scan, clear, hold;
  logic [SEL_W-1:0] idx_q, next_idx;
  logic [OUT_W-1:0] out_q, dec;
  logic             wrap_q, next_wrap;

  assign scan  = (bus.mode == MODE_SCAN);
  assign hold  = !bus.en;
  assign clear = !scan || bus.load;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .hold  (hold),
    .tick  (tick)
  );

  always_comb begin
    next_idx  = idx_q;
    next_wrap = 1'b0;
    if (bus.en) begin
      if (!scan || bus.load) begin
        next_idx = bus.sel;
      end else if (tick) begin
        // an index above last (last lowered mid-scan) wraps instead of climbing
        if (idx_q >= bus.last) begin
          next_idx  = '0;
          next_wrap = 1'b1;
        end else begin
          next_idx = idx_q + 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < OUT_W; i++) begin : g_dec
    assign dec[i] = (next_idx == SEL_W'(i)) ^ ACTIVE_LOW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      out_q  <= OUT_IDLE;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= next_idx;
      wrap_q <= next_wrap;
      out_q  <= bus.en ? dec : OUT_IDLE;
    end
  end

  assign bus.idx  = idx_q;
  assign bus.out  = out_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// Directed checks of scan_decoder across widths, prescale and output polarity.
module tb_scan_decoder;
  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  scan_decoder_if #(.SEL_W(3)) b0 ();
  scan_decoder_if #(.SEL_W(3)) b1 ();
  scan_decoder_if #(.SEL_W(1)) bw1 ();
  scan_decoder_if #(.SEL_W(4)) bw4 ();

  // active-low twin follows the main stimulus
  assign b1.en   = b0.en;
  assign b1.mode = b0.mode;
  assign b1.sel  = b0.sel;
  assign b1.last = b0.last;
  assign b1.load = b0.load;

  scan_decoder #(.SEL_W(3), .PRESCALE(4), .ACTIVE_LOW(1'b0)) u_dut (.clk(clk), .rst_n(rst_n), .bus(b0));
  scan_decoder #(.SEL_W(3), .PRESCALE(4), .ACTIVE_LOW(1'b1)) u_al  (.clk(clk), .rst_n(rst_n), .bus(b1));
  scan_decoder #(.SEL_W(1), .PRESCALE(1), .ACTIVE_LOW(1'b1)) u_w1  (.clk(clk), .rst_n(rst_n), .bus(bw1));
  scan_decoder #(.SEL_W(4), .PRESCALE(1), .ACTIVE_LOW(1'b1)) u_w4  (.clk(clk), .rst_n(rst_n), .bus(bw4));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input logic [2:0] i, input logic [7:0] o, input logic w);
    chk({tag, ".idx"},  16'(b0.idx),  16'(i));
    chk({tag, ".out"},  16'(b0.out),  16'(o));
    chk({tag, ".wrap"}, 16'(b0.wrap), 16'(w));
  endtask

  initial begin
    logic [3:0]  e4;
    logic [15:0] o4;
    logic        e1;
    rst_n = 1'b1;
    b0.en = 0; b0.mode = 0; b0.sel = '0; b0.last = '0; b0.load = 0;
    bw1.en = 0; bw1.mode = 0; bw1.sel = '0; bw1.last = '0; bw1.load = 0;
    bw4.en = 0; bw4.mode = 0; bw4.sel = '0; bw4.last = '0; bw4.load = 0;
    #2 rst_n = 1'b0;
    #1;
    chk_main("reset", 3'd0, 8'h00, 1'b0);
    chk("reset.al_out", 16'(b1.out), 16'h00FF);
    step(2);
    rst_n = 1'b1;

    // direct mode
    b0.en = 1; b0.mode = 0; b0.sel = 3'd6;
    step(1);
    chk_main("direct6", 3'd6, 8'h40, 1'b0);
    chk("direct6.al_out", 16'(b1.out), 16'h00BF);
    b0.en = 0;
    step(1);
    chk_main("direct_dis", 3'd6, 8'h00, 1'b0);
    chk("direct_dis.al_out", 16'(b1.out), 16'h00FF);
    b0.en = 1; b0.sel = 3'd1;
    step(1);
    chk_main("direct1", 3'd1, 8'h02, 1'b0);

    // scan 0..3 with PRESCALE=4
    b0.mode = 1; b0.load = 1; b0.sel = 3'd0; b0.last = 3'd3;
    step(1);
    chk_main("scan_load0", 3'd0, 8'h01, 1'b0);
    b0.load = 0;
    step(3);
    chk_main("scan_hold0", 3'd0, 8'h01, 1'b0);
    step(1);
    chk_main("scan1", 3'd1, 8'h02, 1'b0);
    step(4);
    chk_main("scan2", 3'd2, 8'h04, 1'b0);
    step(4);
    chk_main("scan3", 3'd3, 8'h08, 1'b0);
    step(3);
    chk_main("scan3_hold", 3'd3, 8'h08, 1'b0);
    step(1);
    chk_main("scan_wrap", 3'd0, 8'h01, 1'b1);
    step(1);
    chk_main("scan_wrap_end", 3'd0, 8'h01, 1'b0);

    // load collides with the tick at idx=3
    step(14);
    chk_main("pre_collide", 3'd3, 8'h08, 1'b0);
    b0.load = 1; b0.sel = 3'd2;
    step(1);
    chk_main("collide", 3'd2, 8'h04, 1'b0);
    b0.load = 0;
    step(3);
    chk_main("collide_hold", 3'd2, 8'h04, 1'b0);
    step(1);
    chk_main("collide_next", 3'd3, 8'h08, 1'b0);

    // last lowered below the current index
    b0.load = 1; b0.sel = 3'd6;
    step(1);
    chk_main("load6", 3'd6, 8'h40, 1'b0);
    b0.load = 0; b0.last = 3'd2;
    step(4);
    chk_main("lowered_wrap", 3'd0, 8'h01, 1'b1);
    step(4);
    chk_main("lowered1", 3'd1, 8'h02, 1'b0);
    step(4);
    chk_main("lowered2", 3'd2, 8'h04, 1'b0);
    step(4);
    chk_main("lowered_wrap2", 3'd0, 8'h01, 1'b1);

    // direct -> scan resumes from current idx with a fresh prescale
    b0.mode = 0; b0.sel = 3'd5;
    step(1);
    chk_main("d2s_direct", 3'd5, 8'h20, 1'b0);
    b0.mode = 1; b0.last = 3'd7;
    step(3);
    chk_main("d2s_hold", 3'd5, 8'h20, 1'b0);
    step(1);
    chk_main("d2s_step", 3'd6, 8'h40, 1'b0);

    // en low freezes idx and the prescaler
    step(2);
    b0.en = 0;
    step(3);
    chk_main("en_low", 3'd6, 8'h00, 1'b0);
    b0.en = 1;
    step(1);
    chk_main("en_resume", 3'd6, 8'h40, 1'b0);
    step(1);
    chk_main("en_resume_tick", 3'd7, 8'h80, 1'b0);

    // last = 0 pins the scan at 0 and wraps every tick
    b0.load = 1; b0.sel = 3'd0; b0.last = 3'd0;
    step(1);
    b0.load = 0;
    step(4);
    chk_main("last0_wrap", 3'd0, 8'h01, 1'b1);
    step(1);
    chk_main("last0_gap", 3'd0, 8'h01, 1'b0);
    step(3);
    chk_main("last0_wrap2", 3'd0, 8'h01, 1'b1);

    // asynchronous reset mid-scan
    b0.load = 1; b0.sel = 3'd5; b0.last = 3'd7;
    step(1);
    b0.load = 0;
    chk_main("pre_reset5", 3'd5, 8'h20, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_main("async_reset", 3'd0, 8'h00, 1'b0);
    chk("async_reset.al_out", 16'(b1.out), 16'h00FF);
    step(1);
    rst_n = 1'b1;

    // width/polarity sweep, PRESCALE=1, active-low
    bw1.en = 1; bw1.mode = 1; bw1.load = 1; bw1.sel = 1'b0; bw1.last = 1'b1;
    bw4.en = 1; bw4.mode = 1; bw4.load = 1; bw4.sel = 4'd0; bw4.last = 4'd15;
    step(1);
    chk("w4_load.out", 16'(bw4.out), 16'hFFFE);
    chk("w1_load.out", 16'(bw1.out), 16'h0002);
    bw1.load = 0; bw4.load = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      e4 = 4'(k % 16);
      e1 = 1'(k % 2);
      o4 = ~(16'h0001 << e4);
      chk("w4_idx", 16'(bw4.idx), 16'(e4));
      chk("w4_out", bw4.out, o4);
      chk("w4_wrap", 16'(bw4.wrap), 16'(e4 == 4'd0));
      chk("w4_onecold", 16'($countones(~bw4.out)), 16'd1);
      chk("w1_idx", 16'(bw1.idx), 16'(e1));
      chk("w1_out", 16'(bw1.out), 16'(e1 ? 2'b01 : 2'b10));
      chk("w1_wrap", 16'(bw1.wrap), 16'(e1 == 1'b0));
      if (e4 == 4'd15) chk("w4_idx15_out", bw4.out, 16'h7FFF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
